// File: rtl/clk_div_bank_if.sv
// Control and output bundle for clk_div_bank: run/sync/load controls in,
// per-channel divided clocks and period strobes out.
interface clk_div_bank_if #(
    parameter int NCH = 4,
    parameter int CW  = 16
);
    logic           en;
    logic           sync;
    logic [NCH-1:0] ld;
    logic [CW-1:0]  div;
    logic [NCH-1:0] ch_clk;
    logic [NCH-1:0] ch_stb;

    modport master (
        output en, sync, ld, div,
        input  ch_clk, ch_stb
    );

    modport slave (
        input  en, sync, ld, div,
        output ch_clk, ch_stb
    );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel divided-clock and period-strobe generator. Divisor reloads
// are deferred to period boundaries so the divided clocks never glitch.
module clk_div_bank #(
    parameter int NCH     = 4,
    parameter int CW      = 16,
    parameter int DEF_DIV = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_bank_if.slave  bus
);

    localparam logic [CW-1:0] DEF_DIV_C = CW'(DEF_DIV);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] ZERO_C    = CW'(0);

    // Computed one bit wider so the all-ones divisor cannot overflow.
    function automatic logic [CW:0] ceil_half(input logic [CW-1:0] n);
        logic [CW:0] sum_v;
        sum_v = {1'b0, n} + {{CW{1'b0}}, 1'b1};
        return sum_v >> 1;
    endfunction

    logic [NCH-1:0][CW-1:0] n_q, n_d;
    logic [NCH-1:0][CW-1:0] p_q, p_d;
    logic [NCH-1:0][CW-1:0] c_q, c_d;
    logic [NCH-1:0][CW-1:0] pend_s;
    logic [NCH-1:0]         apply_s;
    logic [NCH-1:0]         clk_q, clk_d;
    logic [NCH-1:0]         stb_q, stb_d;
    logic                   r_q, r_d;

    // Next-state and next-output computation for all channels.
    always_comb begin
        n_d     = n_q;
        p_d     = p_q;
        c_d     = c_q;
        pend_s  = p_q;
        apply_s = '0;
        clk_d   = '0;
        stb_d   = '0;
        r_d     = r_q;

        if (bus.en) begin
            r_d = 1'b1;
        end else begin
            r_d = 1'b0;
        end

        for (int i = 0; i < NCH; i++) begin
            // A load coinciding with an apply point bypasses the pending register.
            if (bus.ld[i]) begin
                pend_s[i] = bus.div;
            end else begin
                pend_s[i] = p_q[i];
            end
            p_d[i] = pend_s[i];

            if (!bus.en) begin
                apply_s[i] = 1'b1;
                c_d[i]     = ZERO_C;
            end else if (bus.sync) begin
                apply_s[i] = 1'b1;
                c_d[i]     = ZERO_C;
            end else if (!r_q) begin
                apply_s[i] = (n_q[i] <= ONE_C);
                c_d[i]     = ZERO_C;
            end else if ((n_q[i] <= ONE_C) || (c_q[i] == (n_q[i] - ONE_C))) begin
                apply_s[i] = 1'b1;
                c_d[i]     = ZERO_C;
            end else begin
                apply_s[i] = 1'b0;
                c_d[i]     = c_q[i] + ONE_C;
            end

            if (apply_s[i]) begin
                n_d[i] = pend_s[i];
            end else begin
                n_d[i] = n_q[i];
            end

            // Outputs are derived from the state being registered this edge.
            if (!r_d) begin
                clk_d[i] = 1'b0;
                stb_d[i] = 1'b0;
            end else if (n_d[i] == ZERO_C) begin
                clk_d[i] = 1'b0;
                stb_d[i] = 1'b0;
            end else if (n_d[i] == ONE_C) begin
                clk_d[i] = 1'b0;
                stb_d[i] = 1'b1;
            end else begin
                clk_d[i] = ({1'b0, c_d[i]} < ceil_half(n_d[i]));
                stb_d[i] = (c_d[i] == ZERO_C);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= {NCH{DEF_DIV_C}};
            p_q   <= {NCH{DEF_DIV_C}};
            c_q   <= '0;
            r_q   <= 1'b0;
            clk_q <= '0;
            stb_q <= '0;
        end else begin
            n_q   <= n_d;
            p_q   <= p_d;
            c_q   <= c_d;
            r_q   <= r_d;
            clk_q <= clk_d;
            stb_q <= stb_d;
        end
    end

    assign bus.ch_clk = clk_q;
    assign bus.ch_stb = stb_q;

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable and divided-clock generator for the image-processing datapath. From the single system clock it produces NCH independent divided clocks and one-cycle period strobes, with runtime-loadable divisors. Divisor changes are glitch-free because they take effect only at period boundaries. A SYNC input re-phases all channels together. Downstream pixel, line and sensor-interface logic uses its strobes as clock enables, staying in the single CLK domain.

## Interface
- NCH, 4, number of output channels (1..16)
- CW, 16, divisor width in bits
- DEF_DIV, 2, divisor loaded into every channel at reset (0..2^CW-1)

- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  global run enable
- SYNC  in  1  restart all channels at count 0 (effective only while EN=1)
- LD  in  NCH  per-channel divisor load strobe
- DIV  in  CW  divisor value, shared by all LD bits
- CH_CLK  out  NCH  divided clock per channel, registered
- CH_STB  out  NCH  one-cycle strobe at the start of each period, registered

## Operation
- Per-channel state:
  - active divisor N[i] (CW bits)
  - pending divisor P[i] (CW bits)
  - counter C[i] (CW bits)
  - run flag R (shared across channels)
- Load: LD[i]=1 captures DIV into P[i]. With several loads before a boundary, the last one wins.
- Apply: P[i] is copied into N[i] at these points only:
  - the period boundary (C[i]=N[i]-1, so C wraps to 0)
  - any cycle with EN=0
  - a SYNC restart
  - while N[i] is 0 or 1
- Bypass: if LD[i] coincides with an apply point, the incoming DIV value is used directly.
- Divisor modes, with R=1:
  - N>=2: C counts 0..N-1 and wraps. CH_STB=1 iff C=0. CH_CLK=1 iff C < ceil(N/2), so duty is 50% for even N and high-biased by one cycle for odd N.
  - N=1: CH_STB=1 every cycle; CH_CLK held 0.
  - N=0: channel disabled; CH_CLK=0, CH_STB=0, C held at 0.
- EN=0: R=0, every C=0, all outputs 0. Pending loads still apply immediately.
- EN 0->1: in the first cycle after EN is sampled high, R=1, C=0 and the outputs show the C=0 state (CH_STB=1; CH_CLK=1 when N>=2).
- SYNC=1 while EN=1: in the next cycle, every channel has C=0 with outputs in the C=0 state and pending divisors applied. Holding SYNC high keeps all channels pinned at C=0. SYNC is ignored while EN=0.
- Arithmetic: unsigned CW-bit compare and increment. ceil(N/2) is computed as (N+1)>>1 at CW+1 bits, so N=2^CW-1 does not overflow.

## Timing
- Reset (RST_N low, asynchronous):
  - CH_CLK=0, CH_STB=0, R=0, C=0
  - N=P=DEF_DIV
- Release from reset is synchronous to CLK; outputs stay 0 until EN is sampled high.
- Outputs are registered. Each cycle they reflect that cycle's C and N: no combinational path from any input to any output.
- Latency:
  - EN or SYNC to first strobe: 1 cycle
  - LD to effect: next period boundary (or 1 cycle at any other apply point)
- Reset mid-period: all state returns immediately to the reset values. No partial pulses are emitted after RST_N deasserts.
- Channels are mutually independent, except for the shared EN/SYNC/R behaviour.

## Test plan
- Reset and idle: hold RST_N=0, then release with EN=0 for 10 cycles -> CH_CLK=0 and CH_STB=0 throughout. With DEF_DIV=2 and EN raised, ch0 CH_CLK toggles 1,0,1,0 and CH_STB pulses every 2 cycles starting 1 cycle after EN.
- Even/odd duty: load ch0 N=4 and ch1 N=3 with EN=0, then raise EN:
  - ch0 CH_CLK = 1,1,0,0 repeating, with CH_STB on cycles 0,4,8
  - ch1 CH_CLK = 1,1,0 repeating, with CH_STB on cycles 0,3,6
- Boundary change: ch0 running at N=8; pulse LD[0] with DIV=2 at C=3 -> the current period completes all 8 cycles, then the 2-cycle period starts. No short high or low phase appears on CH_CLK.
- LD on wrap cycle plus double load:
  - LD with DIV=5 at C=N-1 -> the next period is 5 cycles.
  - Two loads, DIV=6 then DIV=10, within one period -> the next period is 10 cycles.
- SYNC alignment: channels at N=3, 4 and 5 running out of phase; assert SYNC for 1 cycle -> the next cycle has CH_STB=1111 and all C=0. Assert SYNC while EN=0 -> no effect.
- Special divisors and mid-run reset:
  - N=1 -> CH_STB constant 1, CH_CLK 0.
  - N=0 -> both outputs 0.
  - Assert RST_N mid-period -> outputs go to 0 without waiting for a CLK edge, and N returns to DEF_DIV.
